e203_exu_alu_rsltq: RTL and testbench

ALU result queue sitting directly upstream of the ALU write-back stage. It captures ALU results (data, destination register index, instruction tag) when the ALU completes and presents them in arrival order on a valid/ready interface to the ALU write-back stage. This decouples ALU completion from regfile write-back back-pressure. A flush input discards all buffered results on pipeline flush.

---
 rtl/e203_exu_alu_rsltq.sv | 112 +++++++++++
 tb/tb_e203_exu_alu_rsltq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_alu_rsltq.sv
// ALU result queue: buffers ALU results (data, rd index, itag) in arrival
// order and presents the oldest one to the ALU write-back stage over a
// valid/ready handshake. Results that do not write the regfile are accepted
// and dropped. flush_req empties the queue in one cycle.

`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 4
`endif

module e203_exu_alu_rsltq #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         alu_rslt_i_valid,
  output logic                         alu_rslt_i_ready,
  input  logic [`E203_XLEN-1:0]        alu_rslt_i_wdat,
  input  logic [`E203_RFIDX_WIDTH-1:0] alu_rslt_i_rdidx,
  input  logic [`E203_ITAG_WIDTH-1:0]  alu_rslt_i_itag,
  input  logic                         alu_rslt_i_rdwen,

  output logic                         x_alu_wbck_o_valid,
  input  logic                         x_alu_wbck_o_ready,
  output logic [`E203_XLEN-1:0]        x_alu_wbck_o_wdat,
  output logic [`E203_RFIDX_WIDTH-1:0] x_alu_wbck_o_rdidx,
  output logic [`E203_ITAG_WIDTH-1:0]  x_alu_wbck_o_itag,

  input  logic                         flush_req,
  output logic                         rsltq_empty,
  output logic                         rsltq_full,
  output logic [PTR_W:0]               rsltq_cnt
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [`E203_XLEN-1:0]        r_wdat  [DEPTH];
  logic [`E203_RFIDX_WIDTH-1:0] r_rdidx [DEPTH];
  logic [`E203_ITAG_WIDTH-1:0]  r_itag  [DEPTH];

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_cnt;

  logic w_enq;
  logic w_deq;

  // Status and handshakes; a full queue never passes a result straight through.
  assign rsltq_empty        = (r_cnt == '0);
  assign rsltq_full         = (r_cnt == FULL_CNT);
  assign rsltq_cnt          = r_cnt;
  assign alu_rslt_i_ready   = ~rsltq_full & ~flush_req;
  assign x_alu_wbck_o_valid = ~rsltq_empty;

  // rdwen=0 completes the input handshake but stores nothing.
  assign w_enq = alu_rslt_i_valid & alu_rslt_i_ready & alu_rslt_i_rdwen & ~flush_req;
  assign w_deq = x_alu_wbck_o_valid & x_alu_wbck_o_ready & ~flush_req;

  // Head entry is read straight out of storage, so it holds while stalled.
  assign x_alu_wbck_o_wdat  = r_wdat[r_rptr];
  assign x_alu_wbck_o_rdidx = r_rdidx[r_rptr];
  assign x_alu_wbck_o_itag  = r_itag[r_rptr];

  // Storage write at the write pointer on every enqueue.
  // NOTE: storage is reset here because the head payload must read 0 out of
  // reset; flush deliberately leaves it untouched, only pointers are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_wdat[i]  <= '0;
        r_rdidx[i] <= '0;
        r_itag[i]  <= '0;
      end
    end else if (w_enq) begin
      r_wdat[r_wptr]  <= alu_rslt_i_wdat;
      r_rdidx[r_wptr] <= alu_rslt_i_rdidx;
      r_itag[r_wptr]  <= alu_rslt_i_itag;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides any handshake.
  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so the pointer and count updates cannot race each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_req) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_ONE;
      if (w_deq) r_rptr <= r_rptr + PTR_ONE;
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_e203_exu_alu_rsltq.sv
// Testbench for e203_exu_alu_rsltq: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.

`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 4
`endif

module tb_e203_exu_alu_rsltq;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [`E203_XLEN-1:0]        wdat;
    logic [`E203_RFIDX_WIDTH-1:0] rdidx;
    logic [`E203_ITAG_WIDTH-1:0]  itag;
  } entry_t;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         alu_rslt_i_valid;
  logic                         alu_rslt_i_ready;
  logic [`E203_XLEN-1:0]        alu_rslt_i_wdat;
  logic [`E203_RFIDX_WIDTH-1:0] alu_rslt_i_rdidx;
  logic [`E203_ITAG_WIDTH-1:0]  alu_rslt_i_itag;
  logic                         alu_rslt_i_rdwen;
  logic                         x_alu_wbck_o_valid;
  logic                         x_alu_wbck_o_ready;
  logic [`E203_XLEN-1:0]        x_alu_wbck_o_wdat;
  logic [`E203_RFIDX_WIDTH-1:0] x_alu_wbck_o_rdidx;
  logic [`E203_ITAG_WIDTH-1:0]  x_alu_wbck_o_itag;
  logic                         flush_req;
  logic                         rsltq_empty;
  logic                         rsltq_full;
  logic [PTR_W:0]               rsltq_cnt;

  e203_exu_alu_rsltq #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_rslt_i_valid   (alu_rslt_i_valid),
    .alu_rslt_i_ready   (alu_rslt_i_ready),
    .alu_rslt_i_wdat    (alu_rslt_i_wdat),
    .alu_rslt_i_rdidx   (alu_rslt_i_rdidx),
    .alu_rslt_i_itag    (alu_rslt_i_itag),
    .alu_rslt_i_rdwen   (alu_rslt_i_rdwen),
    .x_alu_wbck_o_valid (x_alu_wbck_o_valid),
    .x_alu_wbck_o_ready (x_alu_wbck_o_ready),
    .x_alu_wbck_o_wdat  (x_alu_wbck_o_wdat),
    .x_alu_wbck_o_rdidx (x_alu_wbck_o_rdidx),
    .x_alu_wbck_o_itag  (x_alu_wbck_o_itag),
    .flush_req          (flush_req),
    .rsltq_empty        (rsltq_empty),
    .rsltq_full         (rsltq_full),
    .rsltq_cnt          (rsltq_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: oldest result at index 0.
  entry_t model_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model; called away from the rising edge.
  task automatic compare_all(input string ctx);
    check({ctx, ".valid"}, 64'(x_alu_wbck_o_valid), 64'(model_q.size() != 0));
    check({ctx, ".cnt"},   64'(rsltq_cnt),          64'(model_q.size()));
    check({ctx, ".empty"}, 64'(rsltq_empty),        64'(model_q.size() == 0));
    check({ctx, ".full"},  64'(rsltq_full),         64'(model_q.size() == DEPTH));
    if (model_q.size() != 0) begin
      check({ctx, ".wdat"},  64'(x_alu_wbck_o_wdat),  64'(model_q[0].wdat));
      check({ctx, ".rdidx"}, 64'(x_alu_wbck_o_rdidx), 64'(model_q[0].rdidx));
      check({ctx, ".itag"},  64'(x_alu_wbck_o_itag),  64'(model_q[0].itag));
    end
  endtask

  // One clock cycle: drive at the falling edge, check ready, advance the
  // model at the rising edge, then compare outputs at the next falling edge.
  task automatic step(input string ctx, input bit v, input bit rdwen,
                      input logic [31:0] d, input logic [4:0] ri, input logic [3:0] it,
                      input bit ordy, input bit fl);
    bit     exp_rdy;
    bit     do_deq;
    bit     do_enq;
    entry_t e;
    alu_rslt_i_valid   = v;
    alu_rslt_i_rdwen   = rdwen;
    alu_rslt_i_wdat    = d;
    alu_rslt_i_rdidx   = ri;
    alu_rslt_i_itag    = it;
    x_alu_wbck_o_ready = ordy;
    flush_req          = fl;
    #1;
    exp_rdy = (model_q.size() < DEPTH) && !fl;
    check({ctx, ".i_ready"}, 64'(alu_rslt_i_ready), 64'(exp_rdy));
    do_deq = (model_q.size() != 0) && ordy && !fl;
    do_enq = v && exp_rdy && rdwen;
    e.wdat = d; e.rdidx = ri; e.itag = it;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(e);
    end
    @(negedge clk);
    compare_all(ctx);
  endtask

  task automatic idle(input string ctx, input bit ordy);
    step(ctx, 1'b0, 1'b0, 32'h0, 5'h0, 4'h0, ordy, 1'b0);
  endtask

  initial begin
    rst_n              = 1'b0;
    alu_rslt_i_valid   = 1'b0;
    alu_rslt_i_rdwen   = 1'b0;
    alu_rslt_i_wdat    = '0;
    alu_rslt_i_rdidx   = '0;
    alu_rslt_i_itag    = '0;
    x_alu_wbck_o_ready = 1'b0;
    flush_req          = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and idle.
    compare_all("reset");
    check("reset.i_ready", 64'(alu_rslt_i_ready),   64'd1);
    check("reset.wdat",    64'(x_alu_wbck_o_wdat),  64'd0);
    check("reset.rdidx",   64'(x_alu_wbck_o_rdidx), 64'd0);
    check("reset.itag",    64'(x_alu_wbck_o_itag),  64'd0);
    idle("idle", 1'b1);

    // Fill to full while stalled, try one more, then drain in order.
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 1'b1, 32'h11 * (i + 1), 5'(i + 1), 4'(i), 1'b0, 1'b0);
    check("fill.full_cnt", 64'(rsltq_cnt), 64'd4);
    step("full_push", 1'b1, 1'b1, 32'h55, 5'd5, 4'd4, 1'b0, 1'b0);
    step("full_deq_push", 1'b1, 1'b1, 32'h66, 5'd6, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle("drain", 1'b1);

    // Streaming: one in, one out per cycle, count stays at 1, pointers wrap.
    step("stream0", 1'b1, 1'b1, 32'h100, 5'd1, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++)
      step("stream", 1'b1, 1'b1, 32'h100 + i, 5'(i), 4'(i), 1'b1, 1'b0);
    idle("stream_end", 1'b1);

    // rdwen=0 result is accepted and dropped.
    step("drop_a", 1'b1, 1'b1, 32'hA1, 5'd7, 4'd1, 1'b0, 1'b0);
    step("drop_x", 1'b1, 1'b0, 32'hDEAD, 5'd8, 4'd2, 1'b0, 1'b0);
    step("drop_b", 1'b1, 1'b1, 32'hB2, 5'd9, 4'd3, 1'b0, 1'b0);
    idle("drop_out", 1'b1);
    idle("drop_out", 1'b1);

    // Flush with three held and concurrent enqueue/dequeue.
    for (int i = 0; i < 3; i++)
      step("pre_flush", 1'b1, 1'b1, 32'hC0 + i, 5'(i), 4'(i), 1'b0, 1'b0);
    step("flush", 1'b1, 1'b1, 32'hF00D, 5'd3, 4'd3, 1'b1, 1'b1);
    idle("post_flush", 1'b1);

    // Asynchronous reset between edges with two entries held.
    step("pre_rst", 1'b1, 1'b1, 32'hE1, 5'd1, 4'd1, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 1'b1, 32'hE2, 5'd2, 4'd2, 1'b0, 1'b0);
    alu_rslt_i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    compare_all("async_rst");
    check("async_rst.i_ready", 64'(alu_rslt_i_ready),   64'd1);
    check("async_rst.wdat",    64'(x_alu_wbck_o_wdat),  64'd0);
    check("async_rst.rdidx",   64'(x_alu_wbck_o_rdidx), 64'd0);
    check("async_rst.itag",    64'(x_alu_wbck_o_itag),  64'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    idle("after_rst", 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           $urandom, 5'($urandom), 4'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
